tl_ul_arb2: RTL
===============

Name: tl_ul_arb2

Overview:
- Two-requester TileLink-UL arbiter that shares one 32-bit, 25-bit-address slave port (A request / D response) between master ports m0 and m1.
- Sits in front of the pass-through TL adapter on the peripheral fabric.
- A channel: round-robin arbitration with grant hold. Source IDs are tagged with the master index. D responses are routed back by that tag.
- Per-master outstanding-request limit.

Parameters:
MAX_OUTSTANDING, 4, max in-flight A requests per master (1..15)
CNT_W, 4, outstanding counter width; must satisfy 2^CNT_W > MAX_OUTSTANDING

Ports:
clock  input  1  sole clock, all state on rising edge
reset  input  1  synchronous, active-high
mN_a_valid  input  1  (N=0,1) request valid
mN_a_ready  output  1  request accepted
mN_a_bits  input  78  {opcode3,param3,size3,source8,address25,mask4,data32}
mN_d_valid  output  1  response valid
mN_d_ready  input  1  response accepted
mN_d_bits  output  47  {opcode3,size3,source8,denied1,data32}
s_a_valid  output  1  request to slave
s_a_ready  input  1  slave accepts
s_a_bits  output  78  as mN_a_bits, source rewritten
s_d_valid  input  1  slave response valid
s_d_ready  output  1  response accepted
s_d_bits  input  47  as mN_d_bits
err_flag  output  1  sticky protocol error (TL_ARB_ERRCHK_EN only, else tied 0)

Behaviour:
- Reset state: rr_ptr=0 (m0 preferred), hold_vld=0, cnt0=cnt1=0, err_flag=0.
- Outputs while reset is asserted: s_a_valid=0, mN_a_ready=0, s_d_ready=0, mN_d_valid=0.
- Eligibility: eligN = mN_a_valid && cntN < MAX_OUTSTANDING.
- A grant, hold_vld=0: combinational. If both masters are eligible, grant = rr_ptr; otherwise grant = the single eligible master. No eligible master -> s_a_valid=0.
- A grant, hold_vld=1: grant = hold_idx, regardless of the other master.
- Grant hold: if s_a_valid && !s_a_ready, register hold_vld=1 and hold_idx=grant. Clear hold_vld on the A handshake. This keeps valid/bits stable per TileLink rules.
- Passthrough: s_a_valid = eligible(grant). s_a_bits = mN_a_bits with source replaced by {grant, mN_source[6:0]}.
- A ready: mN_a_ready = (grant==N) && s_a_ready && eligN. The non-granted master sees ready=0.
- Round robin: on an A handshake from master N, rr_ptr <= ~N. rr_ptr is unchanged otherwise.
- A latency: zero cycles (combinational path), no buffering.
- D routing: idx = s_d_bits.source[7].
  - m[idx]_d_valid = s_d_valid; the other master's d_valid = 0.
  - m[idx]_d_bits = s_d_bits with source[7] cleared.
  - s_d_ready = m[idx]_d_ready.
- D latency: zero cycles.
- Counters:
  - cntN +1 on an A handshake from N.
  - cntN -1 on a D handshake to N.
  - Both in the same cycle -> unchanged.
  - Saturate at 0: a D response to a master with cnt=0 does not underflow.
  - cnt==MAX_OUTSTANDING blocks new grants to that master. An already-held grant is never revoked, because the hold only forms while eligible.
- Single-beat only: UL, size<=2, so no burst locking.
- Masters must use source[7]=0. With source[7]=1, bit 7 is overwritten and the request is still forwarded.
- Reset mid-transaction clears all counters and the hold. Responses to pre-reset requests arriving afterward are routed normally; counters saturate at 0.

Optional Feature:
TL_ARB_ERRCHK_EN:
- Defined: err_flag goes high one cycle after any of the following, and stays high until reset:
  - (a) an A handshake with mN source[7]=1;
  - (b) a D handshake to a master whose cnt==0;
  - (c) s_a_bits changing while hold_vld=1.
- Not defined: the checker logic is absent and err_flag is constant 0.

Test Plan:
- Both masters valid continuously, s_a_ready=1, MAX=4, D responses returned each cycle -> A grants alternate m0,m1,m0,m1; s_a source = 0x03,0x85 for m0 src 0x03 and m1 src 0x05.
- m1 valid, s_a_ready=0 for 3 cycles, m0 raises valid in cycle 2 -> grant stays m1 with bits stable; after the m1 handshake the next grant goes to m0.
- m0 issues 4 requests with no D responses -> m0_a_ready=0 thereafter and m1 is still served. One D response with source 0x02 -> m0 regains eligibility next cycle and m0_d_bits.source=0x02.
- D with source 0x87 while m1_d_ready=0 for 2 cycles -> m1_d_valid=1 and s_d_ready=0 during the stall; m0_d_valid stays 0; after acceptance cnt1 decrements by 1.
- In the same cycle, m0 has an A handshake and a D handshake with cnt0=2 -> cnt0 remains 2. Reset asserted mid-stall -> all counters, hold and rr_ptr are cleared on the next edge.
- TL_ARB_ERRCHK_EN defined: m0 sends source 0x80 -> err_flag=1 next cycle and stays high until reset. Macro undefined, same stimulus -> err_flag=0.

Source files
------------

// File: rtl/tl_ul_arb2_if.sv
// TileLink-UL A/D channel bundle shared by the arbiter's master-side and slave-side ports.
// a_bits = {opcode3,param3,size3,source8,address25,mask4,data32}; d_bits = {opcode3,size3,source8,denied1,data32}.
interface tl_ul_arb2_if;
    logic        a_valid;
    logic        a_ready;
    logic [77:0] a_bits;
    logic        d_valid;
    logic        d_ready;
    logic [46:0] d_bits;

    modport master (
        output a_valid, a_bits, d_ready,
        input  a_ready, d_valid, d_bits
    );

    modport slave (
        input  a_valid, a_bits, d_ready,
        output a_ready, d_valid, d_bits
    );
endinterface

// File: rtl/tl_ul_arb2.sv
// Two-master TileLink-UL arbiter: round-robin A grant with hold, source[7] tagging, D routing by tag.
// Define TL_ARB_ERRCHK_EN to build the sticky protocol checker driving err_flag.
module tl_ul_arb2 #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4
) (
    input  logic         clock,
    input  logic         reset,
    tl_ul_arb2_if.slave  m0,
    tl_ul_arb2_if.slave  m1,
    tl_ul_arb2_if.master s,
    output logic         err_flag
);
    localparam int               A_SRC_MSB = 68;
    localparam int               D_SRC_MSB = 40;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt0, cnt1;
    logic             rr_ptr, hold_vld, hold_idx;
    logic             elig0, elig1, grant, grant_elig;
    logic [77:0]      sel_bits, a_bits_out;
    logic [46:0]      d_bits_out;
    logic             d_idx;
    logic             a_hs, a_hs0, a_hs1, d_hs0, d_hs1;

    // Simultaneous issue and retire cancel; retiring at zero never wraps.
    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] r;
        r = c;
        if (inc && !dec)
            r = c + CNT_W'(1);
        else if (dec && !inc && (c != '0))
            r = c - CNT_W'(1);
        return r;
    endfunction

    always_comb begin
        elig0 = m0.a_valid && (cnt0 < CNT_MAX);
        elig1 = m1.a_valid && (cnt1 < CNT_MAX);
        grant = 1'b0;
        if (hold_vld)
            grant = hold_idx;
        else if (elig0 && elig1)
            grant = rr_ptr;
        else if (elig1)
            grant = 1'b1;
        grant_elig = grant ? elig1 : elig0;
        sel_bits   = grant ? m1.a_bits : m0.a_bits;
        a_bits_out = sel_bits;
        a_bits_out[A_SRC_MSB] = grant;
        d_idx      = s.d_bits[D_SRC_MSB];
        d_bits_out = s.d_bits;
        d_bits_out[D_SRC_MSB] = 1'b0;
    end

    assign s.a_valid  = !reset && grant_elig;
    assign s.a_bits   = a_bits_out;
    assign m0.a_ready = !reset && !grant && s.a_ready && elig0;
    assign m1.a_ready = !reset &&  grant && s.a_ready && elig1;

    assign m0.d_valid = !reset && s.d_valid && !d_idx;
    assign m1.d_valid = !reset && s.d_valid &&  d_idx;
    assign m0.d_bits  = d_bits_out;
    assign m1.d_bits  = d_bits_out;
    assign s.d_ready  = !reset && (d_idx ? m1.d_ready : m0.d_ready);

    assign a_hs  = s.a_valid && s.a_ready;
    assign a_hs0 = m0.a_valid && m0.a_ready;
    assign a_hs1 = m1.a_valid && m1.a_ready;
    assign d_hs0 = m0.d_valid && m0.d_ready;
    assign d_hs1 = m1.d_valid && m1.d_ready;

    // Arbitration state and outstanding counters
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr   <= 1'b0;
            hold_vld <= 1'b0;
            hold_idx <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
        end else begin
            if (a_hs) begin
                rr_ptr   <= ~grant;
                hold_vld <= 1'b0;
            end else if (s.a_valid) begin
                hold_vld <= 1'b1;
                hold_idx <= grant;
            end
            cnt0 <= next_cnt(cnt0, a_hs0, d_hs0);
            cnt1 <= next_cnt(cnt1, a_hs1, d_hs1);
        end
    end

`ifdef TL_ARB_ERRCHK_EN
    logic [77:0] s_a_bits_p0;
    logic        err_q;
    logic        err_now;

    // Previous-cycle A bits, compared while a grant is held
    always_ff @(posedge clock) begin
        s_a_bits_p0 <= a_bits_out;
    end

    assign err_now = (a_hs && sel_bits[A_SRC_MSB])
                   || (d_hs0 && (cnt0 == '0))
                   || (d_hs1 && (cnt1 == '0))
                   || (hold_vld && (a_bits_out != s_a_bits_p0));

    always_ff @(posedge clock) begin
        if (reset)
            err_q <= 1'b0;
        else if (err_now)
            err_q <= 1'b1;
    end

    assign err_flag = err_q;
`else
    assign err_flag = 1'b0;
`endif
endmodule
